simf_wr_en_decoder_q: RTL and testbench
=======================================

SIMF_WR_EN_DECODER_Q -- requirements
Module: simf_wr_en_decoder_q

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, decoded-entry queue depth (power of two, 2..16).
REQ-002 SHALL have parameter WFID_WIDTH, default 6, wavefront-ID tag width.
REQ-003 SHALL have parameter SGPR_ADDR_WIDTH, default 12, destination-address width.
REQ-004 SHALL have port clk, input, 1, the only clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, instruction present.
REQ-007 SHALL have port in_ready, output, 1, entry accepted when in_valid&in_ready.
REQ-008 SHALL have port in_opcode, input, 32; [31:24] format, [11:0] opcode.
REQ-009 SHALL have port in_sgpr_dest_addr, input, SGPR_ADDR_WIDTH, VOP3A destination.
REQ-010 SHALL have port in_wfid, input, WFID_WIDTH, tag carried with entry.
REQ-011 SHALL have port flush, input, 1, synchronous queue clear.
REQ-012 SHALL have port out_valid, output, 1, head entry present.
REQ-013 SHALL have port out_ready, input, 1, head popped when out_valid&out_ready.
REQ-014 SHALL have ports out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_illegal, output, 1 each, head entry fields.
REQ-015 SHALL have port out_wfid, output, WFID_WIDTH, head entry tag.
REQ-016 SHALL have port out_count, output, $clog2(FIFO_DEPTH+1), occupancy.

Function
REQ-017 SHALL decode at accept: VOP2 opcodes 003,004,005,008,010,01F,020 and VOP1 006,007,02A,033 -> vgpr=1, vcc=0, sgpr=0.
REQ-018 SHALL decode VOPC compares 000-006,009-00F -> vcc=1, vgpr=0, sgpr=0.
REQ-019 SHALL decode VOP3A compares 000-006,009-00F -> dest==0xE01: vcc=1,sgpr=0; dest[11:9]==3'b110: vcc=0,sgpr=1; otherwise vcc=1,sgpr=1; vgpr=0 in all cases.
REQ-020 SHALL decode VOP3A 103,104,105,108,141 -> vgpr=1, vcc=0, sgpr=0, dest ignored.
REQ-021 SHALL decode any other format/opcode as illegal=1 with all three enables 0 (never X).
REQ-022 SHALL set in_ready = (count < FIFO_DEPTH) & !flush; no full-queue bypass even if popping.
REQ-023 SHALL present an entry accepted at edge N on outputs after edge N (out_valid high cycle N+1) when queue was empty.
REQ-024 SHALL keep head outputs stable while out_valid & !out_ready.
REQ-025 SHALL allow simultaneous push and pop, count unchanged, order preserved.
REQ-026 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-027 SHALL on flush empty the queue at next edge, discarding any same-cycle push or pop.
REQ-028 SHALL drive all head field outputs 0 whenever out_valid=0.

Reset
REQ-029 SHALL on rst clear pointers, out_count=0, out_valid=0, all field outputs 0, sticky state 0, asynchronously, including mid-transfer.
REQ-030 SHALL drive in_ready=1 from first edge after rst deassertion.

Configuration
REQ-031 SHALL compile the illegal trap only under macro SIMF_DEC_ILLEGAL_TRAP_EN.
REQ-032 SHALL, with the macro, add ports out_illegal_sticky (1), out_illegal_wfid (WFID_WIDTH), in_illegal_clr (1); first accepted illegal sets sticky and captures wfid; later illegals leave capture unchanged; in_illegal_clr clears both next edge, set wins on same-cycle clear and new illegal.
REQ-033 SHALL, without the macro, omit those ports and state; per-entry out_illegal remains.

Structure
REQ-034 SHALL place format codes, opcode constants, the entry struct typedef and the decode function in package simf_dec_pkg.
REQ-035 SHALL instantiate one sub-module simf_dec_fifo (generic sync FIFO, parametrised width/depth).

Verification
REQ-036 SHALL test VOP2 0x003 wfid 5 into empty queue -> cycle N+1 out_valid=1, vgpr=1, vcc=0, sgpr=0, out_wfid=5.
REQ-037 SHALL test VOP3A 0x001 with dest 0xE01, 0xC05, 0x010 -> (vcc,sgpr)=(1,0),(0,1),(1,1).
REQ-038 SHALL test 5 pushes with out_ready=0, depth 4 -> in_ready=0 after 4th, out_count=4, 5th held; pop one -> 5th accepted, FIFO order.
REQ-039 SHALL test VOP1 0x0FF wfid 9 with macro -> out_illegal=1, enables 0, sticky=1, captured wfid 9; second illegal wfid 3 -> capture stays 9.
REQ-040 SHALL test flush with count=3 plus same-cycle push -> count=0, out_valid=0 next cycle; rst mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/simf_dec_pkg.sv
// Write-enable decode constants, per-entry flag struct and the decode function.
package simf_dec_pkg;

    localparam logic [7:0]  FMT_VOP2  = 8'h01;
    localparam logic [7:0]  FMT_VOP1  = 8'h02;
    localparam logic [7:0]  FMT_VOPC  = 8'h04;
    localparam logic [7:0]  FMT_VOP3A = 8'h08;

    localparam logic [11:0] DEST_VCC  = 12'hE01;
    localparam logic [2:0]  DEST_SGPR_HI = 3'b110;

    typedef struct packed {
        logic illegal;
        logic vcc;
        logic vgpr;
        logic sgpr;
    } dec_t;

    localparam int DEC_W = $bits(dec_t);

    // Compare opcodes occupy 000-00F except 007/008.
    function automatic logic is_cmp(input logic [11:0] op);
        return (op[11:4] == 8'h00) && (op[3:0] != 4'h7) && (op[3:0] != 4'h8);
    endfunction

    function automatic dec_t dec_wr_en(input logic [31:0] opcode, input logic [11:0] dest);
        dec_t        d;
        logic [11:0] op;
        op = opcode[11:0];
        d  = '{illegal: 1'b1, vcc: 1'b0, vgpr: 1'b0, sgpr: 1'b0};
        case (opcode[31:24])
            FMT_VOP2: begin
                case (op)
                    12'h003, 12'h004, 12'h005, 12'h008,
                    12'h010, 12'h01F, 12'h020: d = '{illegal: 1'b0, vcc: 1'b0, vgpr: 1'b1, sgpr: 1'b0};
                    default: ;
                endcase
            end
            FMT_VOP1: begin
                case (op)
                    12'h006, 12'h007, 12'h02A, 12'h033: d = '{illegal: 1'b0, vcc: 1'b0, vgpr: 1'b1, sgpr: 1'b0};
                    default: ;
                endcase
            end
            FMT_VOPC: begin
                if (is_cmp(op)) d = '{illegal: 1'b0, vcc: 1'b1, vgpr: 1'b0, sgpr: 1'b0};
            end
            FMT_VOP3A: begin
                if (is_cmp(op)) begin
                    if (dest == DEST_VCC)
                        d = '{illegal: 1'b0, vcc: 1'b1, vgpr: 1'b0, sgpr: 1'b0};
                    else if (dest[11:9] == DEST_SGPR_HI)
                        d = '{illegal: 1'b0, vcc: 1'b0, vgpr: 1'b0, sgpr: 1'b1};
                    else
                        d = '{illegal: 1'b0, vcc: 1'b1, vgpr: 1'b0, sgpr: 1'b1};
                end else begin
                    case (op)
                        12'h103, 12'h104, 12'h105, 12'h108,
                        12'h141: d = '{illegal: 1'b0, vcc: 1'b0, vgpr: 1'b1, sgpr: 1'b0};
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/simf_dec_fifo.sv
// Generic synchronous FIFO, power-of-two depth; read data is the combinational head.
// Caller must not push when full or pop when empty; flush clears and overrides push/pop.
module simf_dec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wr_dat,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_MAX = DEPTH;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush)
            r_mem[r_wr_ptr] <= i_wr_dat;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_dat = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_full   = (r_count == CNT_MAX);
    assign o_empty  = (r_count == '0);

endmodule

// File: rtl/simf_wr_en_decoder_q.sv
// Decodes VCC/VGPR/SGPR write enables at accept and queues them; head visible the cycle after accept.
// in_ready drops when full or flushing; illegal-op trap is built only with SIMF_DEC_ILLEGAL_TRAP_EN.
module simf_wr_en_decoder_q
    import simf_dec_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int WFID_WIDTH      = 6,
    parameter int SGPR_ADDR_WIDTH = 12
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [31:0]                        in_opcode,
    input  logic [SGPR_ADDR_WIDTH-1:0]         in_sgpr_dest_addr,
    input  logic [WFID_WIDTH-1:0]              in_wfid,
    input  logic                               flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_vcc_wr_en,
    output logic                               out_vgpr_wr_en,
    output logic                               out_sgpr_wr_en,
    output logic                               out_illegal,
    output logic [WFID_WIDTH-1:0]              out_wfid,
`ifdef SIMF_DEC_ILLEGAL_TRAP_EN
    input  logic                               in_illegal_clr,
    output logic                               out_illegal_sticky,
    output logic [WFID_WIDTH-1:0]              out_illegal_wfid,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    out_count
);

    localparam int EW = DEC_W + WFID_WIDTH;

    dec_t            w_dec;
    dec_t            w_head_dec;
    logic [EW-1:0]   w_wr_dat;
    logic [EW-1:0]   w_rd_dat;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;

    assign w_dec    = dec_wr_en(in_opcode, 12'(in_sgpr_dest_addr));
    assign w_wr_dat = {w_dec, in_wfid};

    assign in_ready  = !w_full && !flush;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    simf_dec_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_wr_dat (w_wr_dat),
        .o_rd_dat (w_rd_dat),
        .o_count  (out_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Empty-queue storage is never exposed: fields read as zero without a head.
    assign w_head_dec     = out_valid ? dec_t'(w_rd_dat[EW-1:WFID_WIDTH]) : '0;
    assign out_wfid       = out_valid ? w_rd_dat[WFID_WIDTH-1:0] : '0;
    assign out_vcc_wr_en  = w_head_dec.vcc;
    assign out_vgpr_wr_en = w_head_dec.vgpr;
    assign out_sgpr_wr_en = w_head_dec.sgpr;
    assign out_illegal    = w_head_dec.illegal;

`ifdef SIMF_DEC_ILLEGAL_TRAP_EN
    logic                  r_illegal_sticky;
    logic [WFID_WIDTH-1:0] r_illegal_wfid;
    logic                  w_ill_set;

    // A new illegal in the clear cycle re-arms with its own wfid.
    assign w_ill_set = w_push && w_dec.illegal && (!r_illegal_sticky || in_illegal_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal_sticky <= 1'b0;
            r_illegal_wfid   <= '0;
        end else if (w_ill_set) begin
            r_illegal_sticky <= 1'b1;
            r_illegal_wfid   <= in_wfid;
        end else if (in_illegal_clr) begin
            r_illegal_sticky <= 1'b0;
            r_illegal_wfid   <= '0;
        end
    end

    assign out_illegal_sticky = r_illegal_sticky;
    assign out_illegal_wfid   = r_illegal_wfid;
`endif

endmodule

// File: tb/tb_simf_wr_en_decoder_q.sv
// Directed bench: decode vector table plus queue, flush, reset and illegal-trap sequences.
module tb_simf_wr_en_decoder_q;

    localparam logic [7:0] F_VOP2  = 8'h01;
    localparam logic [7:0] F_VOP1  = 8'h02;
    localparam logic [7:0] F_VOPC  = 8'h04;
    localparam logic [7:0] F_VOP3A = 8'h08;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_opcode = '0;
    logic [11:0] in_sgpr_dest_addr = '0;
    logic [5:0]  in_wfid = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_illegal;
    logic [5:0]  out_wfid;
    logic [2:0]  out_count;
`ifdef SIMF_DEC_ILLEGAL_TRAP_EN
    logic        in_illegal_clr = 1'b0;
    logic        out_illegal_sticky;
    logic [5:0]  out_illegal_wfid;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    simf_wr_en_decoder_q #(
        .FIFO_DEPTH      (4),
        .WFID_WIDTH      (6),
        .SGPR_ADDR_WIDTH (12)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_opcode          (in_opcode),
        .in_sgpr_dest_addr  (in_sgpr_dest_addr),
        .in_wfid            (in_wfid),
        .flush              (flush),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_vcc_wr_en      (out_vcc_wr_en),
        .out_vgpr_wr_en     (out_vgpr_wr_en),
        .out_sgpr_wr_en     (out_sgpr_wr_en),
        .out_illegal        (out_illegal),
        .out_wfid           (out_wfid),
`ifdef SIMF_DEC_ILLEGAL_TRAP_EN
        .in_illegal_clr     (in_illegal_clr),
        .out_illegal_sticky (out_illegal_sticky),
        .out_illegal_wfid   (out_illegal_wfid),
`endif
        .out_count          (out_count)
    );

    typedef struct {
        logic [7:0]  fmt;
        logic [11:0] op;
        logic [11:0] dest;
        logic [5:0]  wfid;
        logic [3:0]  exp;   // {illegal, vcc, vgpr, sgpr}
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] head();
        return {21'd0, out_valid, out_illegal, out_vcc_wr_en, out_vgpr_wr_en, out_sgpr_wr_en, out_wfid};
    endfunction

    function automatic logic [31:0] mk_head(input logic v, input logic [3:0] f, input logic [5:0] w);
        return {21'd0, v, f, w};
    endfunction

    task automatic drive(input logic [7:0] fmt, input logic [11:0] op, input logic [11:0] dest,
                         input logic [5:0] wfid);
        in_valid          = 1'b1;
        in_opcode         = {fmt, 12'h000, op};
        in_sgpr_dest_addr = dest;
        in_wfid           = wfid;
    endtask

    task automatic push1(input logic [7:0] fmt, input logic [11:0] op, input logic [11:0] dest,
                         input logic [5:0] wfid);
        drive(fmt, op, dest, wfid);
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{F_VOP2,  12'h003, 12'h000, 6'd5,  4'b0010};
        vecs[1]  = '{F_VOP2,  12'h004, 12'hE01, 6'd1,  4'b0010};
        vecs[2]  = '{F_VOP2,  12'h010, 12'h000, 6'd2,  4'b0010};
        vecs[3]  = '{F_VOP2,  12'h020, 12'h000, 6'd3,  4'b0010};
        vecs[4]  = '{F_VOP2,  12'h006, 12'h000, 6'd4,  4'b1000};
        vecs[5]  = '{F_VOP1,  12'h007, 12'h000, 6'd6,  4'b0010};
        vecs[6]  = '{F_VOP1,  12'h033, 12'h000, 6'd7,  4'b0010};
        vecs[7]  = '{F_VOP1,  12'h003, 12'h000, 6'd8,  4'b1000};
        vecs[8]  = '{F_VOPC,  12'h000, 12'h000, 6'd9,  4'b0100};
        vecs[9]  = '{F_VOPC,  12'h006, 12'h000, 6'd10, 4'b0100};
        vecs[10] = '{F_VOPC,  12'h007, 12'h000, 6'd11, 4'b1000};
        vecs[11] = '{F_VOPC,  12'h009, 12'h000, 6'd12, 4'b0100};
        vecs[12] = '{F_VOPC,  12'h00F, 12'h000, 6'd13, 4'b0100};
        vecs[13] = '{F_VOPC,  12'h010, 12'h000, 6'd14, 4'b1000};
        vecs[14] = '{F_VOP3A, 12'h001, 12'hE01, 6'd15, 4'b0100};
        vecs[15] = '{F_VOP3A, 12'h001, 12'hC05, 6'd16, 4'b0001};
        vecs[16] = '{F_VOP3A, 12'h001, 12'h010, 6'd17, 4'b0101};
        vecs[17] = '{F_VOP3A, 12'h103, 12'hE01, 6'd18, 4'b0010};
        vecs[18] = '{F_VOP3A, 12'h141, 12'hC05, 6'd19, 4'b0010};
        vecs[19] = '{F_VOP3A, 12'h107, 12'h000, 6'd20, 4'b1000};
        vecs[20] = '{F_VOP3A, 12'h008, 12'h010, 6'd21, 4'b1000};
        vecs[21] = '{8'h10,   12'h003, 12'h000, 6'd22, 4'b1000};
        vecs[22] = '{F_VOP3A, 12'h00E, 12'hDFF, 6'd23, 4'b0001};
        vecs[23] = '{F_VOP3A, 12'h00E, 12'hE00, 6'd24, 4'b0101};
        vecs[24] = '{F_VOP1,  12'h0FF, 12'h000, 6'd25, 4'b1000};

        // Reset state
        #12;
        chk("rst_head", head(), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Decode table: each entry enters an empty queue and is popped again
        for (int i = 0; i < 25; i++) begin
            push1(vecs[i].fmt, vecs[i].op, vecs[i].dest, vecs[i].wfid);
            chk($sformatf("vec%0d_head", i), head(), mk_head(1'b1, vecs[i].exp, vecs[i].wfid));
            pop1();
            chk($sformatf("vec%0d_empty", i), head(), 32'd0);
        end

        // Fill to depth 4 with out_ready low; 5th is held
        for (int k = 1; k <= 4; k++) push1(F_VOP2, 12'h003, 12'h000, 6'(k));
        chk("full_count", 32'(out_count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(F_VOP2, 12'h005, 12'h000, 6'd5);
        step();
        chk("held_count", 32'(out_count), 32'd4);
        chk("held_head_stable", head(), mk_head(1'b1, 4'b0010, 6'd1));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_one_count", 32'(out_count), 32'd3);
        chk("pop_one_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("fifth_count", 32'(out_count), 32'd4);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("order_%0d", k), 32'(out_wfid), 32'(k));
            pop1();
        end
        chk("drained_count", 32'(out_count), 32'd0);

        // Simultaneous push and pop
        push1(F_VOP2, 12'h003, 12'h000, 6'd1);
        push1(F_VOP2, 12'h003, 12'h000, 6'd2);
        drive(F_VOPC, 12'h000, 12'h000, 6'd3);
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("pushpop_count", 32'(out_count), 32'd2);
        chk("pushpop_head", head(), mk_head(1'b1, 4'b0010, 6'd2));
        pop1();
        chk("pushpop_tail", head(), mk_head(1'b1, 4'b0100, 6'd3));
        pop1();

        // Flush with count 3 and a same-cycle push
        for (int k = 1; k <= 3; k++) push1(F_VOP2, 12'h003, 12'h000, 6'(k));
        chk("preflush_count", 32'(out_count), 32'd3);
        flush = 1'b1;
        drive(F_VOP2, 12'h004, 12'h000, 6'd9);
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(out_count), 32'd0);
        chk("flush_head", head(), 32'd0);

`ifdef SIMF_DEC_ILLEGAL_TRAP_EN
        // Illegal trap: first capture sticks, clear, set-wins on same-cycle clear
        in_illegal_clr = 1'b1;
        step();
        in_illegal_clr = 1'b0;
        chk("trap_cleared", {25'd0, out_illegal_sticky, out_illegal_wfid}, 32'd0);
        push1(F_VOP1, 12'h0FF, 12'h000, 6'd9);
        chk("trap_head", head(), mk_head(1'b1, 4'b1000, 6'd9));
        chk("trap_first", {25'd0, out_illegal_sticky, out_illegal_wfid}, {25'd0, 1'b1, 6'd9});
        pop1();
        push1(F_VOP1, 12'h0FF, 12'h000, 6'd3);
        chk("trap_second", {25'd0, out_illegal_sticky, out_illegal_wfid}, {25'd0, 1'b1, 6'd9});
        pop1();
        in_illegal_clr = 1'b1;
        push1(F_VOPC, 12'h007, 12'h000, 6'd7);
        in_illegal_clr = 1'b0;
        chk("trap_set_wins", {25'd0, out_illegal_sticky, out_illegal_wfid}, {25'd0, 1'b1, 6'd7});
        pop1();
        in_illegal_clr = 1'b1;
        step();
        in_illegal_clr = 1'b0;
        chk("trap_clr", {25'd0, out_illegal_sticky, out_illegal_wfid}, 32'd0);
`endif

        // Reset mid-transfer clears outputs without a clock edge
        push1(F_VOP2, 12'h003, 12'h000, 6'd11);
        push1(F_VOP2, 12'h003, 12'h000, 6'd12);
        drive(F_VOP2, 12'h004, 12'h000, 6'd13);
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_head", head(), 32'd0);
        chk("midrst_count", 32'(out_count), 32'd0);
`ifdef SIMF_DEC_ILLEGAL_TRAP_EN
        chk("midrst_trap", {25'd0, out_illegal_sticky, out_illegal_wfid}, 32'd0);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("postrst_in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
